ckong_kbd_input: RTL and testbench
==================================

# ckong_kbd_input

Input-conditioning stage that sits directly upstream of the Crazy Kong core's `joy_pcfrldu` / `joy_pcfrldu2` ports.

- Consumes the hps_io PS/2 key event word and the merged joystick word.
- Tracks per-key pressed state and applies the optional orientation remap.
- Shapes coin requests into fixed-length pulses with a lockout gap.
- Produces registered 7-bit player-control vectors.

## Interface
Parameters:
- `COIN_PULSE`, 1_200_000: coin output high time in `clk_sys` cycles (100 ms at 12 MHz); must be ≥1.
- `COIN_GAP`, 2_400_000: lockout after each pulse in cycles; must be ≥1.

Ports:
- `clk_sys` in 1: system clock (12 MHz core clock). Single clock domain.
- `reset_n` in 1: synchronous, active-low reset.
- `ps2_key` in 11: hps_io key event; [10] toggles per event, [9] pressed, [8:0] scan code ([8] = E0 extended).
- `joy` in 16: joystick bits; [0] right, [1] left, [2] down, [3] up, [4] fire, [5] start, [6] coin.
- `rot` in 1: 1 = horizontal orientation, P1/P2 directions remapped.
- `joy_p1` out 7: {coin, start, fire, right, left, down, up} for player 1.
- `joy_p2` out 7: same bit layout, for player 2.

## Operation
- **Event detect.**
  - `tog_q` holds the previous `ps2_key[10]`.
  - An event occurs on the cycle where `ps2_key[10] != tog_q`.
  - On reset, `tog_q` loads the current `ps2_key[10]`, so no event fires after reset.
- **Key flags.** On an event, the matching flag is set to `ps2_key[9]`.
  - Arrow keys ignore bit 8:
    - X75 → up1
    - X72 → down1
    - X6B → left1
    - X74 → right1
  - All other codes require an exact 9-bit match:
    - 029 and 014 → fire1
    - 016 and 005 → start1
    - 01E and 006 → start2
    - 02E → coin1
    - 036 → coin2
    - 02D → up2
    - 02B → down2
    - 023 → left2
    - 034 → right2
    - 01C → fire2
  - Unmapped codes are ignored.
  - Fire1 and start1/start2 are each shared by two keys: the flag follows the most recent event from either key (last-event-wins, no reference counting).
- **Merge.**
  - Each direction, fire and start = key flag OR the corresponding `joy` bit. `joy` feeds both players.
  - Coin requests:
    - `coin_req1` = coin1 flag OR `joy[6]`.
    - `coin_req2` = coin2 flag.
- **Rotate.** When `rot`=1, applied per player after the merge:
  - up ← left
  - down ← right
  - left ← down
  - right ← up
  - Fire, start and coin are unaffected.
- **Coin shaper.** One instance per player. States:
  - IDLE: a rising edge of the request (vs. its registered previous value) → PULSE, counter loads `COIN_PULSE-1`.
  - PULSE: output 1. Counter decrements; at 0 → GAP, counter loads `COIN_GAP-1`.
  - GAP: output 0. Counter decrements; at 0 → IDLE.
  - Request edges in PULSE or GAP are dropped, not queued.
  - A request held high through GAP does not retrigger; a new rising edge is needed.
  - Counter width is `$clog2(max(COIN_PULSE, COIN_GAP))`, minimum 1.

## Timing
- Reset values:
  - `joy_p1` = `joy_p2` = 0
  - all key flags 0
  - both shapers in IDLE, counters 0
  - request history 0
  - A request already high at reset release counts as a rising edge.
- PS/2 latency: event at edge N → flag updated at N+1 → output reflects it at N+2.
- `joy` / `rot` latency: 1 cycle to the output.
- Coin latency:
  - Request high at edge N → coin output 1 from N+2.
  - Output stays high for exactly `COIN_PULSE` cycles.
  - Earliest next pulse starts `COIN_PULSE+COIN_GAP+1` cycles after the previous one began.
- Reset asserted mid-pulse: coin output is 0 on the cycle after the reset edge.
- Events arrive at most once per cycle; consecutive toggles on adjacent cycles are both processed.

## Configuration
- `CKONG_INPUT_COIN_SHAPER_EN` defined:
  - Shapers are instantiated.
  - Coin bits behave as described in Operation.
- Undefined:
  - Coin bit = registered `coin_req` level, with the same 2-cycle PS/2 latency as other keys.
  - No shaper logic and no lockout.
  - `COIN_PULSE` / `COIN_GAP` are unused.

## Structure
- Package `ckong_input_pkg` holds:
  - scan-code localparams (e.g. `SC_UP`, `SC_COIN1`)
  - `joy` bit indices
  - output bit positions: `JB_UP`=0 … `JB_COIN`=6
  - `typedef enum logic [1:0] {CS_IDLE, CS_PULSE, CS_GAP} coin_state_t`
- Sub-module `ckong_coin_shaper`:
  - parameters `COIN_PULSE` and `COIN_GAP`
  - ports `clk_sys`, `reset_n`, `req`, `coin`
  - instantiated twice under the macro

## Test plan
Run with `COIN_PULSE`=4, `COIN_GAP`=6, macro defined unless noted.
- **Directions and release.** Toggle with code 0x175, pressed=1 → `joy_p1[0]`=1 two cycles later. Toggle with 0x175, pressed=0 → bit clears. Code 0x075 behaves identically.
- **Rotate.** `rot`=1, `joy`=0x0002 (left) → `joy_p1`=0x01 (up) after 1 cycle. With `rot`=0, the same input → 0x04.
- **Coin shaping.**
  - Press 0x02E and hold for 20 cycles → `joy_p1[6]` high for exactly 4 cycles, then low; no retrigger.
  - Release, then press again inside GAP → no pulse.
  - Press after GAP ends → a new 4-cycle pulse.
- **Reset and overlap.**
  - Assert `reset_n`=0 during the 2nd pulse cycle → both outputs 0 the next cycle.
  - Release reset with `ps2_key[10]` already toggled → no flag change.
  - Unmapped code 0x0AA → outputs unchanged.
- **Player independence.** Keys 0x02D, 0x01C and 0x036 → `joy_p2` = 0x01, then 0x11, then coin pulse; `joy_p1` stays 0.
- **Macro undefined.** Holding 0x02E for 20 cycles → `joy_p1[6]` high for 20 cycles, delayed by 2.

Source files
------------

// File: rtl/ckong_kbd_input_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ckong_input_pkg
// Description : Shared constants and types for the Crazy Kong input stage:
//               PS/2 scan codes, joystick bit indices, player-control bit
//               positions, coin shaper states and small helper functions.
// Revision    : 1.0 - initial release
// ============================================================================
package ckong_input_pkg;

  // Arrow keys: only the low byte is compared, so E0 and keypad forms both match
  localparam logic [8:0] SC_UP       = 9'h075;
  localparam logic [8:0] SC_DOWN     = 9'h072;
  localparam logic [8:0] SC_LEFT     = 9'h06B;
  localparam logic [8:0] SC_RIGHT    = 9'h074;

  // Exact 9-bit matches
  localparam logic [8:0] SC_FIRE1_A  = 9'h029;
  localparam logic [8:0] SC_FIRE1_B  = 9'h014;
  localparam logic [8:0] SC_START1_A = 9'h016;
  localparam logic [8:0] SC_START1_B = 9'h005;
  localparam logic [8:0] SC_START2_A = 9'h01E;
  localparam logic [8:0] SC_START2_B = 9'h006;
  localparam logic [8:0] SC_COIN1    = 9'h02E;
  localparam logic [8:0] SC_COIN2    = 9'h036;
  localparam logic [8:0] SC_UP2      = 9'h02D;
  localparam logic [8:0] SC_DOWN2    = 9'h02B;
  localparam logic [8:0] SC_LEFT2    = 9'h023;
  localparam logic [8:0] SC_RIGHT2   = 9'h034;
  localparam logic [8:0] SC_FIRE2    = 9'h01C;

  // Bit indices inside the merged joystick word
  localparam int JOY_RIGHT = 0;
  localparam int JOY_LEFT  = 1;
  localparam int JOY_DOWN  = 2;
  localparam int JOY_UP    = 3;
  localparam int JOY_FIRE  = 4;
  localparam int JOY_START = 5;
  localparam int JOY_COIN  = 6;

  // Bit positions in the 7-bit player-control vector
  localparam int JB_UP    = 0;
  localparam int JB_DOWN  = 1;
  localparam int JB_LEFT  = 2;
  localparam int JB_RIGHT = 3;
  localparam int JB_FIRE  = 4;
  localparam int JB_START = 5;
  localparam int JB_COIN  = 6;

  typedef enum logic [1:0] {
    CS_IDLE  = 2'd0,
    CS_PULSE = 2'd1,
    CS_GAP   = 2'd2
  } coin_state_t;

  // Horizontal cabinet: directions rotate, fire/start/coin pass through
  function automatic logic [6:0] rotate_ctl(input logic [6:0] v);
    logic [6:0] r;
    r           = v;
    r[JB_UP]    = v[JB_LEFT];
    r[JB_DOWN]  = v[JB_RIGHT];
    r[JB_LEFT]  = v[JB_DOWN];
    r[JB_RIGHT] = v[JB_UP];
    return r;
  endfunction

  // Counter width able to hold max(a,b)-1, never below one bit
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    int unsigned w;
    m = (a > b) ? a : b;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ckong_kbd_input_if.sv
`default_nettype none
// ============================================================================
// Interface   : ckong_kbd_input_if
// Description : Keyboard/joystick inputs and the two player-control outputs
//               of the Crazy Kong input stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface ckong_kbd_input_if;
  logic [10:0] ps2_key;
  logic [15:0] joy;
  logic        rot;
  logic [6:0]  joy_p1;
  logic [6:0]  joy_p2;

  // Source of key/joystick events, consumer of player controls
  modport master (output ps2_key, joy, rot, input joy_p1, joy_p2);
  // The input-conditioning stage itself
  modport slave  (input ps2_key, joy, rot, output joy_p1, joy_p2);
endinterface
`default_nettype wire

// File: rtl/ckong_kbd_input_coin_shaper.sv
`default_nettype none
// ============================================================================
// Module      : ckong_coin_shaper
// Description : Turns a coin request level into a fixed COIN_PULSE-cycle pulse
//               followed by a COIN_GAP-cycle lockout. Only a rising edge seen
//               in IDLE starts a pulse; edges during PULSE/GAP are dropped.
//               Used only when CKONG_INPUT_COIN_SHAPER_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module ckong_coin_shaper
  import ckong_input_pkg::*;
#(
  parameter int COIN_PULSE = 1_200_000,
  parameter int COIN_GAP   = 2_400_000
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic req,
  output logic coin
);

  localparam int unsigned        c_cnt_w    = cnt_width(COIN_PULSE, COIN_GAP);
  localparam logic [c_cnt_w-1:0] c_pulse_ld = c_cnt_w'(COIN_PULSE - 1);
  localparam logic [c_cnt_w-1:0] c_gap_ld   = c_cnt_w'(COIN_GAP - 1);

  coin_state_t        r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_req_q;
  logic               r_coin;

  assign coin = r_coin;

  // Pulse/lockout sequencer with a registered coin output
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_state <= CS_IDLE;
      r_cnt   <= '0;
      r_req_q <= 1'b0;
      r_coin  <= 1'b0;
    end else begin
      r_req_q <= req;
      case (r_state)
        CS_IDLE: begin
          if (req && !r_req_q) begin
            r_state <= CS_PULSE;
            r_cnt   <= c_pulse_ld;
            r_coin  <= 1'b1;
          end
        end
        CS_PULSE: begin
          if (r_cnt == '0) begin
            r_state <= CS_GAP;
            r_cnt   <= c_gap_ld;
            r_coin  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        CS_GAP: begin
          if (r_cnt == '0) begin
            r_state <= CS_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= CS_IDLE;
          r_coin  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/ckong_kbd_input.sv
`default_nettype none
// ============================================================================
// Module      : ckong_kbd_input
// Description : Input conditioning for the Crazy Kong core. Decodes hps_io
//               PS/2 key events into per-key flags, merges them with the
//               joystick word, applies the horizontal-cabinet remap and
//               registers two 7-bit player-control vectors
//               {coin, start, fire, right, left, down, up}.
//               Macro CKONG_INPUT_COIN_SHAPER_EN: when defined, coin bits are
//               fixed-length pulses with lockout; otherwise they follow the
//               coin request level.
// Revision    : 1.0 - initial release
// ============================================================================
module ckong_kbd_input
  import ckong_input_pkg::*;
#(
  parameter int COIN_PULSE = 1_200_000,
  parameter int COIN_GAP   = 2_400_000
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  ckong_kbd_input_if.slave bus
);

  logic       r_tog_q;
  logic       w_event;
  logic       w_pressed;
  logic [8:0] w_code;
  logic [6:0] r_key_p1;
  logic [6:0] r_key_p2;
  logic [6:0] w_joy_ctl;
  logic [6:0] w_mrg_p1;
  logic [6:0] w_mrg_p2;
  logic [6:0] w_rot_p1;
  logic [6:0] w_rot_p2;
  logic       w_coin1;
  logic       w_coin2;
  logic       w_unused_joy;

  assign w_event      = bus.ps2_key[10] != r_tog_q;
  assign w_pressed    = bus.ps2_key[9];
  assign w_code       = bus.ps2_key[8:0];
  assign w_unused_joy = ^bus.joy[15:7];

  // Track the toggle bit and update key flags on each new event
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_tog_q  <= bus.ps2_key[10];
      r_key_p1 <= '0;
      r_key_p2 <= '0;
    end else begin
      r_tog_q <= bus.ps2_key[10];
      if (w_event) begin
        if (w_code[7:0] == SC_UP[7:0])    r_key_p1[JB_UP]    <= w_pressed;
        if (w_code[7:0] == SC_DOWN[7:0])  r_key_p1[JB_DOWN]  <= w_pressed;
        if (w_code[7:0] == SC_LEFT[7:0])  r_key_p1[JB_LEFT]  <= w_pressed;
        if (w_code[7:0] == SC_RIGHT[7:0]) r_key_p1[JB_RIGHT] <= w_pressed;
        case (w_code)
          SC_FIRE1_A, SC_FIRE1_B:   r_key_p1[JB_FIRE]  <= w_pressed;
          SC_START1_A, SC_START1_B: r_key_p1[JB_START] <= w_pressed;
          SC_START2_A, SC_START2_B: r_key_p2[JB_START] <= w_pressed;
          SC_COIN1:                 r_key_p1[JB_COIN]  <= w_pressed;
          SC_COIN2:                 r_key_p2[JB_COIN]  <= w_pressed;
          SC_UP2:                   r_key_p2[JB_UP]    <= w_pressed;
          SC_DOWN2:                 r_key_p2[JB_DOWN]  <= w_pressed;
          SC_LEFT2:                 r_key_p2[JB_LEFT]  <= w_pressed;
          SC_RIGHT2:                r_key_p2[JB_RIGHT] <= w_pressed;
          SC_FIRE2:                 r_key_p2[JB_FIRE]  <= w_pressed;
          default:                  ;
        endcase
      end
    end
  end

  // Reorder the joystick word into control-vector layout (shared by both players)
  always_comb begin
    w_joy_ctl           = '0;
    w_joy_ctl[JB_UP]    = bus.joy[JOY_UP];
    w_joy_ctl[JB_DOWN]  = bus.joy[JOY_DOWN];
    w_joy_ctl[JB_LEFT]  = bus.joy[JOY_LEFT];
    w_joy_ctl[JB_RIGHT] = bus.joy[JOY_RIGHT];
    w_joy_ctl[JB_FIRE]  = bus.joy[JOY_FIRE];
    w_joy_ctl[JB_START] = bus.joy[JOY_START];
  end

  // Joystick coin only feeds player 1's coin request
  assign w_mrg_p1 = r_key_p1 | w_joy_ctl | {bus.joy[JOY_COIN], 6'b0};
  assign w_mrg_p2 = r_key_p2 | w_joy_ctl;
  assign w_rot_p1 = bus.rot ? rotate_ctl(w_mrg_p1) : w_mrg_p1;
  assign w_rot_p2 = bus.rot ? rotate_ctl(w_mrg_p2) : w_mrg_p2;

`ifdef CKONG_INPUT_COIN_SHAPER_EN
  ckong_coin_shaper #(
    .COIN_PULSE (COIN_PULSE),
    .COIN_GAP   (COIN_GAP)
  ) u_coin1 (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .req     (w_mrg_p1[JB_COIN]),
    .coin    (w_coin1)
  );

  ckong_coin_shaper #(
    .COIN_PULSE (COIN_PULSE),
    .COIN_GAP   (COIN_GAP)
  ) u_coin2 (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .req     (w_mrg_p2[JB_COIN]),
    .coin    (w_coin2)
  );
`else
  localparam int c_unused_params = COIN_PULSE + COIN_GAP;

  assign w_coin1 = w_mrg_p1[JB_COIN];
  assign w_coin2 = w_mrg_p2[JB_COIN];
`endif

  // Registered player-control vectors
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      bus.joy_p1 <= '0;
      bus.joy_p2 <= '0;
    end else begin
      bus.joy_p1 <= {w_coin1, w_rot_p1[5:0]};
      bus.joy_p2 <= {w_coin2, w_rot_p2[5:0]};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ckong_kbd_input.sv
`default_nettype none
// ============================================================================
// Module      : tb_ckong_kbd_input
// Description : Scoreboard bench for ckong_kbd_input with COIN_PULSE=4,
//               COIN_GAP=6. Coin expectations follow the
//               CKONG_INPUT_COIN_SHAPER_EN build option.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ckong_kbd_input;

  typedef struct packed {
    int         cyc;
    int         ph;
    logic [6:0] p1;
    logic [6:0] p2;
  } exp_t;

`ifdef CKONG_INPUT_COIN_SHAPER_EN
  localparam logic [23:0] MASK_A = 24'h000078;   // offsets 3..6
  localparam logic [23:0] MASK_B = 24'h1E0078;   // offsets 3..6, 17..20
  localparam logic [23:0] MASK_C = 24'h000078;   // offsets 3..6
  localparam bit          SHAPED = 1'b1;
`else
  localparam logic [23:0] MASK_A = 24'h3FFFFC;   // offsets 2..21
  localparam logic [23:0] MASK_B = 24'h03030C;   // offsets 2,3,8,9,16,17
  localparam logic [23:0] MASK_C = 24'h000FFC;   // offsets 2..11
  localparam bit          SHAPED = 1'b0;
`endif

  logic clk_sys = 1'b0;
  logic reset_n;
  int   cyc     = 0;
  int   ph      = 0;
  int   n_cmp   = 0;
  int   n_bad   = 0;
  logic tog     = 1'b0;
  exp_t exp_q[$];

  ckong_kbd_input_if bus ();

  ckong_kbd_input #(
    .COIN_PULSE (4),
    .COIN_GAP   (6)
  ) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic goto(input int t);
    while (cyc < t) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic push_exp(input int off, input logic [6:0] p1, input logic [6:0] p2);
    exp_t e;
    e.cyc = cyc + off;
    e.ph  = ph;
    e.p1  = p1;
    e.p2  = p2;
    exp_q.push_back(e);
  endtask

  task automatic key(input logic [8:0] code, input logic pr);
    tog         = ~tog;
    bus.ps2_key = {tog, pr, code};
  endtask

  task automatic key_chk(input logic [8:0] code, input logic pr,
                         input logic [6:0] o1, input logic [6:0] o2,
                         input logic [6:0] n1, input logic [6:0] n2);
    key(code, pr);
    push_exp(1, o1, o2);
    push_exp(2, n1, n2);
    step(3);
  endtask

  task automatic joy_chk(input logic [15:0] j, input logic r,
                         input logic [6:0] n1, input logic [6:0] n2);
    bus.joy = j;
    bus.rot = r;
    push_exp(1, n1, n2);
    step(2);
  endtask

  task automatic push_window(input int len, input logic [23:0] mask,
                             input logic [6:0] b1, input logic [6:0] b2, input logic on_p2);
    logic [6:0] cbit;
    for (int i = 1; i < len; i++) begin
      cbit = mask[i] ? 7'h40 : 7'h00;
      if (on_p2) push_exp(i, b1, b2 | cbit);
      else       push_exp(i, b1 | cbit, b2);
    end
  endtask

  // Monitor: pop every expectation that is due this cycle and compare
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk_sys);
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (e.cyc != cyc) begin
          n_bad++;
          $display("FAIL ph%0d late: sampled at cycle %0d, required cycle %0d", e.ph, cyc, e.cyc);
        end else if (bus.joy_p1 !== e.p1 || bus.joy_p2 !== e.p2) begin
          n_bad++;
          $display("FAIL ph%0d cycle %0d: joy_p1=%02h joy_p2=%02h, required joy_p1=%02h joy_p2=%02h",
                   e.ph, cyc, bus.joy_p1, bus.joy_p2, e.p1, e.p2);
        end
      end
    end
  end

  // Stimulus
  initial begin : stim
    int c0;
    logic [6:0] e2_p1, e2_p2, e3_p1, e3_p2;
    reset_n     = 1'b0;
    bus.ps2_key = '0;
    bus.joy     = '0;
    bus.rot     = 1'b0;

    // Reset state
    ph = 0;
    step(2);
    push_exp(1, 7'h00, 7'h00);
    goto(4);
    reset_n = 1'b1;
    push_exp(1, 7'h00, 7'h00);
    push_exp(2, 7'h00, 7'h00);
    step(3);

    // Directions, release, shared keys
    ph = 1;
    key_chk(9'h175, 1'b1, 7'h00, 7'h00, 7'h01, 7'h00);
    key_chk(9'h175, 1'b0, 7'h01, 7'h00, 7'h00, 7'h00);
    key_chk(9'h075, 1'b1, 7'h00, 7'h00, 7'h01, 7'h00);
    key_chk(9'h075, 1'b0, 7'h01, 7'h00, 7'h00, 7'h00);
    key_chk(9'h16B, 1'b1, 7'h00, 7'h00, 7'h04, 7'h00);
    key_chk(9'h074, 1'b1, 7'h04, 7'h00, 7'h0C, 7'h00);
    key_chk(9'h16B, 1'b0, 7'h0C, 7'h00, 7'h08, 7'h00);
    key_chk(9'h074, 1'b0, 7'h08, 7'h00, 7'h00, 7'h00);
    key_chk(9'h029, 1'b1, 7'h00, 7'h00, 7'h10, 7'h00);
    key_chk(9'h014, 1'b0, 7'h10, 7'h00, 7'h00, 7'h00);
    key_chk(9'h01E, 1'b1, 7'h00, 7'h00, 7'h00, 7'h20);
    key_chk(9'h006, 1'b0, 7'h00, 7'h20, 7'h00, 7'h00);

    // Joystick merge and rotation
    ph = 2;
    joy_chk(16'h0002, 1'b1, 7'h01, 7'h01);
    joy_chk(16'h0002, 1'b0, 7'h04, 7'h04);
    joy_chk(16'h0001, 1'b1, 7'h02, 7'h02);
    joy_chk(16'h0030, 1'b1, 7'h30, 7'h30);
    joy_chk(16'h0000, 1'b1, 7'h00, 7'h00);
    key_chk(9'h075, 1'b1, 7'h00, 7'h00, 7'h08, 7'h00);
    key_chk(9'h075, 1'b0, 7'h08, 7'h00, 7'h00, 7'h00);
    joy_chk(16'h0000, 1'b0, 7'h00, 7'h00);

    // Coin held 20 cycles
    ph = 3;
    c0 = cyc;
    push_window(24, MASK_A, 7'h00, 7'h00, 1'b0);
    key(9'h02E, 1'b1);
    goto(c0 + 20);
    key(9'h02E, 1'b0);
    goto(c0 + 28);

    // Coin re-press inside GAP, then after GAP
    ph = 4;
    c0 = cyc;
    push_window(24, MASK_B, 7'h00, 7'h00, 1'b0);
    key(9'h02E, 1'b1);
    goto(c0 + 2);  key(9'h02E, 1'b0);
    goto(c0 + 6);  key(9'h02E, 1'b1);
    goto(c0 + 8);  key(9'h02E, 1'b0);
    goto(c0 + 14); key(9'h02E, 1'b1);
    goto(c0 + 16); key(9'h02E, 1'b0);
    goto(c0 + 28);

    // Reset during a pulse, toggle held across reset release
    ph = 5;
    if (SHAPED) begin
      e2_p1 = 7'h00; e2_p2 = 7'h00; e3_p1 = 7'h40; e3_p2 = 7'h00;
    end else begin
      e2_p1 = 7'h40; e2_p2 = 7'h00; e3_p1 = 7'h40; e3_p2 = 7'h40;
    end
    c0 = cyc;
    push_exp(1, 7'h00, 7'h00);
    push_exp(2, e2_p1, e2_p2);
    push_exp(3, e3_p1, e3_p2);
    push_exp(4, 7'h40, 7'h40);
    for (int i = 5; i <= 10; i++) push_exp(i, 7'h00, 7'h00);
    key(9'h02E, 1'b1);
    goto(c0 + 1); key(9'h036, 1'b1);
    goto(c0 + 4); reset_n = 1'b0;
    goto(c0 + 5); key(9'h175, 1'b1);
    goto(c0 + 7); reset_n = 1'b1;
    goto(c0 + 11);

    // Unmapped and non-exact codes leave outputs unchanged
    ph = 6;
    key_chk(9'h075, 1'b1, 7'h00, 7'h00, 7'h01, 7'h00);
    key_chk(9'h0AA, 1'b1, 7'h01, 7'h00, 7'h01, 7'h00);
    key_chk(9'h12E, 1'b1, 7'h01, 7'h00, 7'h01, 7'h00);
    key_chk(9'h175, 1'b0, 7'h01, 7'h00, 7'h00, 7'h00);

    // Player 2 independence
    ph = 7;
    key_chk(9'h02D, 1'b1, 7'h00, 7'h00, 7'h00, 7'h01);
    key_chk(9'h01C, 1'b1, 7'h00, 7'h01, 7'h00, 7'h11);
    c0 = cyc;
    push_window(16, MASK_C, 7'h00, 7'h11, 1'b1);
    key(9'h036, 1'b1);
    goto(c0 + 10); key(9'h036, 1'b0);
    goto(c0 + 18);
    key_chk(9'h02D, 1'b0, 7'h00, 7'h11, 7'h00, 7'h10);
    key_chk(9'h01C, 1'b0, 7'h00, 7'h10, 7'h00, 7'h00);

    // Drain the scoreboard
    for (int k = 0; k < 50 && exp_q.size() > 0; k++) step(1);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
